// File: rtl/coa_counter_pkg.sv
// Shared definitions for the COA lab counters: direction encoding and the
// count value at which each direction wraps.
package coa_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Counting up wraps after MODULO-1, counting down wraps after 0.
    function automatic int boundary_value(input logic dir, input int modulo);
        return (dir == DIR_UP) ? (modulo - 1) : 0;
    endfunction

endpackage

// File: rtl/tff_mod_counter_if.sv
// Control and status bundle of the modulo counter; the driver owns the
// controls and the counter owns the status.
interface tff_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             load_err;

    modport master (
        output en, up, load, d,
        input  q, tc, wrap, load_err
    );

    modport slave (
        input  en, up, load, d,
        output q, tc, wrap, load_err
    );
endinterface

// File: rtl/tff_cell.sv
// Single toggle flip-flop: q inverts on each rising clk while t is high.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);
    logic q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else if (t) begin
            q_q <= ~q_q;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-N up/down counter built from T cells; each cell toggles wherever
// the computed next count differs from the current count.
module tff_mod_counter
    import coa_counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 10
) (
    input  logic              clk,
    input  logic              rst,
    tff_mod_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_Q     = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MODULO_EXT = (WIDTH + 1)'(MODULO);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] toggle;
    logic             wrap_q;
    logic             wrap_d;
    logic             load_err_q;
    logic             load_err_d;
    logic             d_in_range;

    // Widened by one bit so MODULO == 2**WIDTH compares correctly.
    assign d_in_range = ({1'b0, bus.d} < MODULO_EXT);

    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            if (d_in_range) begin
                count_d = bus.d;
            end else begin
                count_d    = '0;
                load_err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (bus.up == DIR_UP) begin
                if (count_q == MAX_Q) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_Q;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    assign toggle = count_q ^ count_d;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (toggle[gi]),
            .q   (count_q[gi])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    // Combinational so a cascaded stage can use it as its enable this cycle.
    assign bus.tc       = bus.en && (count_q == WIDTH'(boundary_value(bus.up, MODULO)));
    assign bus.q        = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_tff_mod_counter.sv
// Directed bench for the modulo counter: a decimal (MODULO=10) instance and
// a binary (MODULO=16) instance driven from hand-computed vector tables.
module tb_tff_mod_counter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    typedef struct {
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] d;
        logic [3:0] exp_q;
        logic       exp_tc;
        logic       exp_wrap;
        logic       exp_lerr;
    } vec_t;

    vec_t dec_vecs[$];
    vec_t bin_vecs[$];

    tff_mod_counter_if #(.WIDTH(4)) b1 ();
    tff_mod_counter_if #(.WIDTH(4)) b2 ();

    tff_mod_counter #(.WIDTH(4), .MODULO(10)) dut_dec (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    tff_mod_counter #(.WIDTH(4), .MODULO(16)) dut_bin (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, input logic up, input logic load,
                                input logic [3:0] d, input logic [3:0] eq,
                                input logic etc, input logic ew, input logic el);
        vec_t v;
        v.en = en; v.up = up; v.load = load; v.d = d;
        v.exp_q = eq; v.exp_tc = etc; v.exp_wrap = ew; v.exp_lerr = el;
        return v;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Apply one vector to the chosen instance, clock it, then compare.
    task automatic run_vec(input vec_t v, input bit bin, input int idx);
        string tag;
        tag = bin ? "bin" : "dec";
        if (bin) begin
            b2.en = v.en; b2.up = v.up; b2.load = v.load; b2.d = v.d;
        end else begin
            b1.en = v.en; b1.up = v.up; b1.load = v.load; b1.d = v.d;
        end
        @(posedge clk);
        #2;
        if (bin) begin
            check($sformatf("%s[%0d].q", tag, idx), int'(b2.q), int'(v.exp_q));
            check($sformatf("%s[%0d].tc", tag, idx), int'(b2.tc), int'(v.exp_tc));
            check($sformatf("%s[%0d].wrap", tag, idx), int'(b2.wrap), int'(v.exp_wrap));
            check($sformatf("%s[%0d].load_err", tag, idx), int'(b2.load_err), int'(v.exp_lerr));
            $display("%s[%0d] en=%0d up=%0d load=%0d d=%0d -> q=%0d tc=%0d wrap=%0d load_err=%0d",
                     tag, idx, v.en, v.up, v.load, v.d, b2.q, b2.tc, b2.wrap, b2.load_err);
        end else begin
            check($sformatf("%s[%0d].q", tag, idx), int'(b1.q), int'(v.exp_q));
            check($sformatf("%s[%0d].tc", tag, idx), int'(b1.tc), int'(v.exp_tc));
            check($sformatf("%s[%0d].wrap", tag, idx), int'(b1.wrap), int'(v.exp_wrap));
            check($sformatf("%s[%0d].load_err", tag, idx), int'(b1.load_err), int'(v.exp_lerr));
            $display("%s[%0d] en=%0d up=%0d load=%0d d=%0d -> q=%0d tc=%0d wrap=%0d load_err=%0d",
                     tag, idx, v.en, v.up, v.load, v.d, b1.q, b1.tc, b1.wrap, b1.load_err);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        b1.en = 1'b0; b1.up = 1'b1; b1.load = 1'b0; b1.d = '0;
        b2.en = 1'b0; b2.up = 1'b1; b2.load = 1'b0; b2.d = '0;

        // Decimal instance: up wrap from 0 through 9 and on to 2.
        dec_vecs.push_back(mk(0, 1, 1, 4'd0, 4'd0, 0, 0, 0));
        for (int i = 1; i <= 12; i++) begin
            dec_vecs.push_back(mk(1, 1, 0, 4'd0, 4'((i) % 10), (i % 10) == 9, i == 10, 0));
        end
        // Down wrap from 2.
        dec_vecs.push_back(mk(0, 1, 1, 4'd2, 4'd2, 0, 0, 0));
        dec_vecs.push_back(mk(1, 0, 0, 4'd0, 4'd1, 0, 0, 0));
        dec_vecs.push_back(mk(1, 0, 0, 4'd0, 4'd0, 1, 0, 0));
        dec_vecs.push_back(mk(1, 0, 0, 4'd0, 4'd9, 0, 1, 0));
        dec_vecs.push_back(mk(1, 0, 0, 4'd0, 4'd8, 0, 0, 0));
        // Load beats en at the boundary, then out-of-range loads.
        dec_vecs.push_back(mk(1, 1, 0, 4'd0, 4'd9, 1, 0, 0));
        dec_vecs.push_back(mk(1, 1, 1, 4'd5, 4'd5, 0, 0, 0));
        dec_vecs.push_back(mk(0, 1, 1, 4'd12, 4'd0, 0, 0, 1));
        dec_vecs.push_back(mk(0, 1, 0, 4'd0, 4'd0, 0, 0, 0));
        dec_vecs.push_back(mk(0, 1, 1, 4'd10, 4'd0, 0, 0, 1));
        dec_vecs.push_back(mk(0, 1, 1, 4'd9, 4'd9, 0, 0, 0));
        // Hold at 4 for five edges.
        dec_vecs.push_back(mk(0, 1, 1, 4'd4, 4'd4, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            dec_vecs.push_back(mk(0, 1, 0, 4'd0, 4'd4, 0, 0, 0));
        end
        // Direction flips at the top boundary: no wrap.
        dec_vecs.push_back(mk(0, 1, 1, 4'd9, 4'd9, 0, 0, 0));
        dec_vecs.push_back(mk(1, 0, 0, 4'd0, 4'd8, 0, 0, 0));

        // Binary instance: 14 -> 15 -> 0, full-range load, down wrap.
        bin_vecs.push_back(mk(0, 1, 1, 4'd14, 4'd14, 0, 0, 0));
        bin_vecs.push_back(mk(1, 1, 0, 4'd0, 4'd15, 1, 0, 0));
        bin_vecs.push_back(mk(1, 1, 0, 4'd0, 4'd0, 0, 1, 0));
        bin_vecs.push_back(mk(0, 1, 1, 4'd15, 4'd15, 0, 0, 0));
        bin_vecs.push_back(mk(0, 1, 0, 4'd0, 4'd15, 0, 0, 0));
        bin_vecs.push_back(mk(0, 0, 1, 4'd0, 4'd0, 0, 0, 0));
        bin_vecs.push_back(mk(1, 0, 0, 4'd0, 4'd15, 0, 1, 0));

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        #2;
        check("reset.q", int'(b1.q), 0);
        check("reset.wrap", int'(b1.wrap), 0);
        check("reset.load_err", int'(b1.load_err), 0);
        $display("reset: q=%0d wrap=%0d load_err=%0d", b1.q, b1.wrap, b1.load_err);

        // Count to 7, then assert reset between edges.
        rst = 1'b0;
        b1.en = 1'b1; b1.up = 1'b1;
        @(posedge clk);
        #2;
        check("first_edge.q", int'(b1.q), 1);
        $display("first edge after reset: q=%0d", b1.q);
        repeat (6) @(posedge clk);
        #2;
        check("count7.q", int'(b1.q), 7);
        $display("counted: q=%0d", b1.q);
        rst = 1'b1;
        #1;
        check("async_rst.q", int'(b1.q), 0);
        check("async_rst.wrap", int'(b1.wrap), 0);
        check("async_rst.load_err", int'(b1.load_err), 0);
        $display("async reset mid-cycle: q=%0d wrap=%0d load_err=%0d", b1.q, b1.wrap, b1.load_err);
        @(posedge clk);
        #1;
        check("rst_held.q", int'(b1.q), 0);
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("post_rst.q", int'(b1.q), 1);
        $display("released reset: q=%0d", b1.q);

        for (int i = 0; i < dec_vecs.size(); i++) begin
            run_vec(dec_vecs[i], 1'b0, i);
        end

        // tc follows en/up within the same cycle at q=0.
        b1.load = 1'b1; b1.d = 4'd0; b1.en = 1'b0;
        @(posedge clk);
        #2;
        b1.load = 1'b0;
        b1.en = 1'b1; b1.up = 1'b0;
        #1;
        check("tc_comb.down_at_0", int'(b1.tc), 1);
        b1.up = 1'b1;
        #1;
        check("tc_comb.up_at_0", int'(b1.tc), 0);
        b1.up = 1'b0; b1.en = 1'b0;
        #1;
        check("tc_comb.en_low", int'(b1.tc), 0);
        $display("tc combinational at q=%0d: checked", b1.q);
        b1.en = 1'b0; b1.load = 1'b0;

        for (int i = 0; i < bin_vecs.size(); i++) begin
            run_vec(bin_vecs[i], 1'b1, i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tff_mod_counter.md
Name: tff_mod_counter

Overview:
- Synchronous modulo-N up/down counter built from toggle-flip-flop cells; the consumer stage of the T flip-flop.
- Each bit is a T cell whose toggle input is computed from the current count, direction and control inputs.
- Provides a count bus, a terminal-count flag and a registered wrap pulse for cascading or driving display/sequencer logic in the COA lab designs.

Parameters:
- WIDTH, 4, number of count bits / T cells.
- MODULO, 10, count range 0..MODULO-1; legal range 2..2**WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load, overrides en
- d  input  WIDTH  load value
- q  output  WIDTH  current count
- tc  output  1  terminal count, combinational: 1 when en=1 and q is at the wrap boundary (up and q==MODULO-1, or down and q==0)
- wrap  output  1  registered one-cycle pulse; high in the cycle after the count wrapped
- load_err  output  1  registered one-cycle pulse; high in the cycle after an out-of-range load

Behaviour:
- Reset: rst high forces q=0, wrap=0 and load_err=0 immediately, independent of clk. Reset asserted mid-count discards the count. First count edge is the first rising clk after rst deasserts.
- Structure: next = f(q, en, up, load, d). Each T cell receives T[i] = q[i] ^ next[i]. Cell i toggles on the clk edge when T[i]=1.
- Priority per edge: load > en > hold.
- Load with d < MODULO: q <= d.
- Load with d >= MODULO: q <= 0 and load_err=1 for one cycle. wrap stays 0.
- en=1, up=1: q <= q+1. From MODULO-1 the count goes to 0 and wrap=1 for the next cycle.
- en=1, up=0: q <= q-1. From 0 the count goes to MODULO-1 and wrap=1 for the next cycle.
- en=0 with no load: all T[i]=0 and q holds. wrap and load_err are 0.
- Latency: one clk from a control input to q. wrap and load_err are coincident with the wrapped or loaded q value.
- tc reflects only the current q, en and up. It is not registered and is usable as the en of a cascaded stage in the same cycle.
- Changing direction at the boundary applies the new direction on that edge. Example: q=MODULO-1 with up switching to 0 gives q=MODULO-2 and no wrap.
- load and en asserted together: the load wins, and no wrap is generated even if q was at the boundary.
- MODULO=2**WIDTH: the counter is a plain binary counter and load_err can never fire.
- All arithmetic is WIDTH bits wide with no overflow beyond the modulo compare. q never holds a value >= MODULO.

Decomposition:
- Shared package coa_counter_pkg holds:
  - direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0;
  - a helper function returning the boundary value for a given direction and MODULO.
- One sub-module, tff_cell: single T flip-flop with clk, rst (async, active-high), T, q. It is instantiated WIDTH times by generate.
- Next-state, tc and the pulse registers live in the top module.

Test Plan:
- Reset: drive rst=1 mid-count at q=7 with clk running -> q=0, wrap=0 and load_err=0 without waiting for an edge. Release rst with en=1, up=1 -> q=1 after the first edge.
- Up wrap (WIDTH=4, MODULO=10): en=1, up=1 for 12 edges from 0. Expected:
  - q goes 1..9, 0, 1, 2;
  - tc=1 only while q=9;
  - wrap=1 only in the cycle where q=0 after 9.
- Down wrap: load d=2, then en=1, up=0 for 4 edges -> q=1, 0, 9, 8. wrap is high only with the first 9. tc is high only while q=0.
- Load priority and range: at q=9 with en=1, up=1, load=1, d=5 -> q=5 and wrap=0. Next, load d=12 -> q=0 and load_err=1 for exactly one cycle.
- Hold and direction change: en=0 for 5 edges at q=4 -> q stays 4 and tc=0. At q=9 set up=0 with en=1 -> q=8 and no wrap.
- Binary mode (MODULO=16): count up from 14 -> q=15, 0. wrap is high with q=0. Loading d=15 never asserts load_err.
